// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, imem request/response handshake, decode hand-off.
// Optional misaligned-PC fault state enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] nextPC,
  output logic [63:0] currentPC,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [63:0] imemAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        instrValid,
  output logic [31:0] instruction,
  input  logic        instrReady,
  output logic [31:0] retireCount,
  output logic        fault
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
`endif

  state_t state;

  // Request and presentation flags decode straight from the state register.
  assign imemReqValid = (state == FETCH);
  assign instrValid   = (state == HOLD);
  assign imemAddr     = currentPC;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      currentPC   <= RESET_PC;
      instruction <= 32'h0;
      retireCount <= 32'h0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (imemReqReady) state <= WAIT;
        WAIT: begin
          if (imemRespValid) begin
            instruction <= imemRespData;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instrReady) begin
            retireCount <= retireCount + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
            // Misaligned target is kept verbatim so it is visible when debugging.
            currentPC <= nextPC;
            if (nextPC[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              state <= FETCH;
            end
`else
            currentPC <= nextPC & ~64'h3;
            state     <= FETCH;
`endif
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        FAULT:   state <= FAULT;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
